muldiv_sequencer: RTL and testbench

- Sequences the shared multiplier and divisor on behalf of the main control FSM.
- Accepts one mult/div request at a time and issues a one-cycle start pulse to the selected unit.
- Waits for that unit's fim, then produces the HI/LO write enables and source selects.
- Reports completion or a divide-by-zero exception back to control, so control no longer needs per-unit wait states.

---
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Issues one start pulse to the multiplier or divisor, waits for it to finish, then writes HI/LO or reports divide-by-zero.
// Done comes at least 3 cycles after accept; one request at a time, req_ready only in IDLE. MULDIV_TIMEOUT_EN adds a WAIT watchdog.
module muldiv_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic req_valid,
  input  logic req_op,
  output logic req_ready,
  output logic mult_start,
  input  logic mult_fim,
  output logic div_start,
  input  logic div_fim,
  input  logic div_zero,
  output logic hi_write,
  output logic lo_write,
  output logic hilo_src,
  output logic busy,
  output logic done,
  output logic div_zero_exc,
  output logic timeout_exc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WRITE,
    S_EXC
`ifdef MULDIV_TIMEOUT_EN
    , S_TMO
`endif
  } state_t;

  state_t state_q, state_d;
  logic   op_q, op_d;
  logic   fim_sel;

`ifdef MULDIV_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          limit_hit;

  // cnt_q counts completed WAIT edges, so the limit is the TIMEOUT_CYCLES-th edge
  assign limit_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_param;
  assign unused_timeout_param = |TIMEOUT_CYCLES;
`endif

  // Only the unit that was started is listened to
  assign fim_sel = op_q ? div_fim : mult_fim;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
`ifdef MULDIV_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef MULDIV_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
`ifdef MULDIV_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (op_q && div_zero) begin
          state_d = S_EXC;
        end else if (fim_sel) begin
          state_d = S_WRITE;
`ifdef MULDIV_TIMEOUT_EN
        end else if (limit_hit) begin
          state_d = S_TMO;
`endif
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
`ifdef MULDIV_TIMEOUT_EN
      S_TMO:   state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Outputs decode state_q/op_q only, so an async reset clears them at once
  always_comb begin
    req_ready    = 1'b0;
    mult_start   = 1'b0;
    div_start    = 1'b0;
    hi_write     = 1'b0;
    lo_write     = 1'b0;
    hilo_src     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    div_zero_exc = 1'b0;
    timeout_exc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_START: begin
        mult_start = ~op_q;
        div_start  = op_q;
        hilo_src   = op_q;
      end
      S_WAIT: begin
        hilo_src = op_q;
      end
      S_WRITE: begin
        hi_write = 1'b1;
        lo_write = 1'b1;
        hilo_src = op_q;
        done     = 1'b1;
      end
      S_EXC: begin
        div_zero_exc = 1'b1;
        done         = 1'b1;
      end
`ifdef MULDIV_TIMEOUT_EN
      S_TMO: begin
        timeout_exc = 1'b1;
        done        = 1'b1;
      end
`endif
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_muldiv_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic req_valid, req_op, req_ready;
  logic mult_start, mult_fim, div_start, div_fim, div_zero;
  logic hi_write, lo_write, hilo_src, busy, done, div_zero_exc, timeout_exc;

  int n_chk  = 0;
  int n_pass = 0;
  int ms_cnt = 0;
  int ds_cnt = 0;

  muldiv_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_ready    (req_ready),
    .mult_start   (mult_start),
    .mult_fim     (mult_fim),
    .div_start    (div_start),
    .div_fim      (div_fim),
    .div_zero     (div_zero),
    .hi_write     (hi_write),
    .lo_write     (lo_write),
    .hilo_src     (hilo_src),
    .busy         (busy),
    .done         (done),
    .div_zero_exc (div_zero_exc),
    .timeout_exc  (timeout_exc)
  );

  always #5 clock = ~clock;

  // {req_ready, mult_start, div_start, hi_write, lo_write, hilo_src, busy, done, div_zero_exc, timeout_exc}
  logic [9:0] obs;
  assign obs = {req_ready, mult_start, div_start, hi_write, lo_write,
                hilo_src, busy, done, div_zero_exc, timeout_exc};

  localparam logic [9:0] O_IDLE   = 10'b1000000000;
  localparam logic [9:0] O_MSTART = 10'b0100001000;
  localparam logic [9:0] O_MWAIT  = 10'b0000001000;
  localparam logic [9:0] O_MWRITE = 10'b0001101100;
  localparam logic [9:0] O_DSTART = 10'b0010011000;
  localparam logic [9:0] O_DWAIT  = 10'b0000011000;
  localparam logic [9:0] O_DWRITE = 10'b0001111100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one cycle; tally start pulses seen in the new cycle
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    ms_cnt += int'(mult_start);
    ds_cnt += int'(div_start);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0;
    mult_fim = 1'b0; div_fim = 1'b0; div_zero = 1'b0;
    #3;
    check("reset_out", obs, O_IDLE);
    @(negedge clock); reset = 1'b0;
    step(); check("idle", obs, O_IDLE);

    // Multiply: fim at edge 5, WRITE in cycle 6, IDLE in cycle 7
    ms_cnt = 0; ds_cnt = 0;
    req_valid = 1'b1; req_op = 1'b0;
    step(); check("mul_c1_start", obs, O_MSTART); req_valid = 1'b0;
    step(); check("mul_c2_wait", obs, O_MWAIT);
    step(); step();
    step(); check("mul_c5_wait", obs, O_MWAIT); mult_fim = 1'b1;
    step(); check("mul_c6_write", obs, O_MWRITE); mult_fim = 1'b0;
    step(); check("mul_c7_idle", obs, O_IDLE);
    check("mul_starts", ms_cnt, 1);
    check("mul_no_div_start", ds_cnt, 0);

    // Divide: fim on the 3rd WAIT edge (edge 4)
    ms_cnt = 0; ds_cnt = 0;
    req_valid = 1'b1; req_op = 1'b1;
    step(); check("div_c1_start", obs, O_DSTART); req_valid = 1'b0;
    step(); check("div_c2_wait", obs, O_DWAIT);
    step();
    step(); div_fim = 1'b1;
    step(); check("div_c5_write", obs, O_DWRITE); div_fim = 1'b0;
    step(); check("div_c6_idle", obs, O_IDLE);
    check("div_starts", ds_cnt, 1);
    check("div_no_mul_start", ms_cnt, 0);

    // Divide by zero with div_fim: EXC wins
    req_valid = 1'b1; req_op = 1'b1;
    step(); req_valid = 1'b0;
    step(); div_zero = 1'b1; div_fim = 1'b1;
    step();
    check("dz_exc", div_zero_exc, 1'b1);
    check("dz_done", done, 1'b1);
    check("dz_no_write", {hi_write, lo_write}, 2'b00);
    check("dz_no_tmo", timeout_exc, 1'b0);
    div_zero = 1'b0; div_fim = 1'b0;
    step(); check("dz_idle", obs, O_IDLE);

    // Interference during a multiply
    ms_cnt = 0; ds_cnt = 0;
    req_valid = 1'b1; req_op = 1'b0;
    step(); req_valid = 1'b0;
    step(); div_fim = 1'b1; div_zero = 1'b1; req_valid = 1'b1; req_op = 1'b1;
    step(); check("intf_wait_a", obs, O_MWAIT);
    step(); check("intf_wait_b", obs, O_MWAIT);
    div_fim = 1'b0; div_zero = 1'b0; req_valid = 1'b0; req_op = 1'b0;
    mult_fim = 1'b1;
    step(); check("intf_write", obs, O_MWRITE); mult_fim = 1'b0;
    step(); check("intf_idle", obs, O_IDLE);
    check("intf_mul_starts", ms_cnt, 1);
    check("intf_div_starts", ds_cnt, 0);

    // Async reset mid-WAIT
    req_valid = 1'b1; req_op = 1'b0;
    step(); req_valid = 1'b0;
    step(); check("rw_wait", obs, O_MWAIT);
    #2 reset = 1'b1;
    #1 check("rw_async_clear", obs, O_IDLE);
    @(negedge clock); reset = 1'b0; mult_fim = 1'b1;
    step(); check("rw_no_write_a", obs, O_IDLE);
    step(); check("rw_no_write_b", obs, O_IDLE);
    mult_fim = 1'b0;

    // Minimum latency and req_valid held across back-to-back operations
    ms_cnt = 0;
    req_valid = 1'b1; req_op = 1'b0;
    step(); check("b2b_start", obs, O_MSTART);
    step(); check("b2b_wait", obs, O_MWAIT); mult_fim = 1'b1;
    step(); check("b2b_write_c3", obs, O_MWRITE); mult_fim = 1'b0;
    step(); check("b2b_gap_idle", obs, O_IDLE);
    step(); check("b2b_second_start", obs, O_MSTART); req_valid = 1'b0;
    step(); mult_fim = 1'b1;
    step(); check("b2b_second_write", obs, O_MWRITE); mult_fim = 1'b0;
    step(); check("b2b_end_idle", obs, O_IDLE);
    check("b2b_starts", ms_cnt, 2);

`ifdef MULDIV_TIMEOUT_EN
    // No fim: TMO after 8 WAIT edges (cycle 10)
    req_valid = 1'b1; req_op = 1'b0;
    step(); req_valid = 1'b0;
    for (int c = 2; c <= 9; c++) step();
    check("tmo_c9_wait", obs, O_MWAIT);
    step();
    check("tmo_exc", timeout_exc, 1'b1);
    check("tmo_done", done, 1'b1);
    check("tmo_no_write", {hi_write, lo_write, div_zero_exc}, 3'b000);
    step(); check("tmo_idle", obs, O_IDLE);

    // fim on the 8th WAIT edge beats the watchdog
    req_valid = 1'b1; req_op = 1'b1;
    step(); req_valid = 1'b0;
    for (int c = 2; c <= 9; c++) step();
    div_fim = 1'b1;
    step(); check("tmo_fim_write", obs, O_DWRITE); div_fim = 1'b0;
    step(); check("tmo_fim_idle", obs, O_IDLE);
`else
    // Without the watchdog WAIT holds indefinitely
    req_valid = 1'b1; req_op = 1'b0;
    step(); req_valid = 1'b0;
    for (int c = 2; c <= 80; c++) step();
    check("nowd_still_wait", obs, O_MWAIT);
    mult_fim = 1'b1;
    step(); check("nowd_write", obs, O_MWRITE); mult_fim = 1'b0;
    step(); check("nowd_idle", obs, O_IDLE);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
